// File: rtl/normalize_exp_update_pipe_pkg.sv
// rtl/normalize_exp_update_pipe_pkg.sv - shared widths, constants and flag types for the post-adder normalizer
package normalize_exp_update_pipe_pkg;

    // Width of the prenormalized adder field for a given stored significand width
    function automatic int calc_pre_w(input int sig_w);
        return 3 * (sig_w + 1) + 8;
    endfunction

    // Width of the normalized window handed to the rounder
    function automatic int calc_norm_w(input int sig_w);
        return sig_w + 4;
    endfunction

    // Width needed to express any shift inside the prenormalized field
    function automatic int calc_shamt_w(input int sig_w);
        return $clog2(calc_pre_w(sig_w));
    endfunction

    // Largest alignment shift; signals the addend fell entirely below the product
    function automatic int calc_shamt_max(input int sig_w);
        return 2 * (sig_w + 1) + 8;
    endfunction

    typedef struct packed {
        logic exp_correction;
        logic zero;
        logic underflow;
    } flags_t;

endpackage

// File: rtl/norm_corr_shift.sv
// rtl/norm_corr_shift.sv - 0..3-bit leading-one correction shift with exponent adjust
module norm_corr_shift #(
    parameter int PRE_W  = 167,
    parameter int EXP1_W = 13
) (
    input  logic        [PRE_W-1:0]  shifted1,
    input  logic signed [EXP1_W-1:0] exp1,
    output logic        [PRE_W-1:0]  shifted2,
    output logic signed [EXP1_W-1:0] exp2,
    output logic        [1:0]        corr,
    output logic                     exp_correction
);

    // The LZA may be short by up to 3 positions; pull the leading one into the MSB
    always_comb begin
        corr = 2'd3;
        casez (shifted1[PRE_W-1 -: 3])
            3'b1??:  corr = 2'd0;
            3'b01?:  corr = 2'd1;
            3'b001:  corr = 2'd2;
            default: corr = 2'd3;
        endcase
        shifted2       = shifted1 << corr;
        exp2           = exp1 - $signed({{(EXP1_W-2){1'b0}}, corr});
        exp_correction = ~shifted1[PRE_W-1];
    end

endmodule

// File: rtl/normalize_exp_update_pipe.sv
// rtl/normalize_exp_update_pipe.sv - two-stage post-adder normalizer with exponent update and flow control
module normalize_exp_update_pipe
    import normalize_exp_update_pipe_pkg::*;
#(
    parameter int SIG_WIDTH = 52,
    parameter int EXP_WIDTH = 11,
    localparam int PRE_W    = calc_pre_w(SIG_WIDTH),
    localparam int NORM_W   = calc_norm_w(SIG_WIDTH),
    localparam int SHAMT_W  = calc_shamt_w(SIG_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PRE_W-1:0]     prenormalized,
    input  logic [SHAMT_W-1:0]   shamt,
    input  logic [SHAMT_W-1:0]   lza_shamt,
    input  logic                 c_exp_is_small,
    input  logic [EXP_WIDTH-1:0] res_exp,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NORM_W-1:0]    normalized,
    output logic                 sticky,
    output logic [EXP_WIDTH-1:0] normalized_exp,
    output logic                 exp_correction,
    output logic                 zero_out,
    output logic                 underflow
);

    localparam int EXP1_W    = EXP_WIDTH + 2;
    localparam int SHAMT_MAX = calc_shamt_max(SIG_WIDTH);
    localparam logic signed [EXP1_W-1:0] EXP_THREE = 3;

    typedef struct packed {
        logic        [PRE_W-1:0]  shifted1;
        logic signed [EXP1_W-1:0] exp1;
        logic                     zero;
    } s1_t;

    typedef struct packed {
        logic [NORM_W-1:0]    normalized;
        logic                 sticky;
        logic [EXP_WIDTH-1:0] exp;
        flags_t               flags;
    } s2_t;

    logic s1_valid, s2_valid;
    logic s1_adv, s2_adv;
    s1_t  s1_d, s1_q;
    s2_t  s2_d, s2_q;

    logic                     portion;
    logic [SHAMT_W:0]         shift;
    logic signed [EXP1_W-1:0] res_ext, lza_ext, cis_ext, max_ext;

    logic        [PRE_W-1:0]  shifted2;
    logic signed [EXP1_W-1:0] exp2;
    logic        [1:0]        corr_unused;
    logic                     exp_corr;

    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;

    // Coarse shift: either the alignment shift or the LZA-driven shift when the sum sits low
    always_comb begin
        portion  = (shamt >= SHAMT_W'(SIG_WIDTH + 4));
        res_ext  = $signed({2'b00, res_exp});
        lza_ext  = $signed(EXP1_W'(lza_shamt));
        cis_ext  = $signed(EXP1_W'(c_exp_is_small));
        max_ext  = $signed(EXP1_W'(shamt == SHAMT_W'(SHAMT_MAX)));
        s1_d     = '0;
        if (portion) begin
            shift     = (SHAMT_W+1)'(lza_shamt) + (SHAMT_W+1)'(SIG_WIDTH + 3);
            s1_d.exp1 = res_ext - lza_ext + EXP_THREE + cis_ext - max_ext;
        end else begin
            shift     = {1'b0, shamt};
            s1_d.exp1 = res_ext + $signed(EXP1_W'(1));
        end
        s1_d.shifted1 = prenormalized << shift;
        s1_d.zero     = ~|prenormalized;
    end

    norm_corr_shift #(
        .PRE_W  (PRE_W),
        .EXP1_W (EXP1_W)
    ) u_norm_corr_shift (
        .shifted1       (s1_q.shifted1),
        .exp1           (s1_q.exp1),
        .shifted2       (shifted2),
        .exp2           (exp2),
        .corr           (corr_unused),
        .exp_correction (exp_corr)
    );

    // Output window, sticky and flags; a zero sum forces a clean zero result
    always_comb begin
        s2_d                      = '0;
        s2_d.flags.exp_correction = exp_corr;
        if (s1_q.zero) begin
            s2_d.flags.zero = 1'b1;
        end else begin
            s2_d.normalized      = shifted2[PRE_W-1 -: NORM_W];
            s2_d.sticky          = |shifted2[PRE_W-NORM_W-1:0];
            s2_d.exp             = exp2[EXP_WIDTH-1:0];
            s2_d.flags.underflow = exp2[EXP1_W-1] || (exp2 == '0);
        end
    end

    // Stage valid bits follow the elastic handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s1_adv) s1_valid <= in_valid;
            if (s2_adv) s2_valid <= s1_valid;
        end
    end

    // Stage data registers load only when their stage advances
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            if (s1_adv) s1_q <= s1_d;
            if (s2_adv) s2_q <= s2_d;
        end
    end

    assign normalized     = s2_q.normalized;
    assign sticky         = s2_q.sticky;
    assign normalized_exp = s2_q.exp;
    assign exp_correction = s2_q.flags.exp_correction;
    assign zero_out       = s2_q.flags.zero;
    assign underflow      = s2_q.flags.underflow;

endmodule

// File: tb/tb_normalize_exp_update_pipe.sv
// tb/tb_normalize_exp_update_pipe.sv - scoreboard bench for SP and DP normalizer instances
module tb_normalize_exp_update_pipe;

    localparam int SP_SW = 23, SP_EW = 8,  SP_PW = 80,  SP_NW = 27, SP_SAW = 7;
    localparam int DP_SW = 52, DP_EW = 11, DP_PW = 167, DP_NW = 56, DP_SAW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              sp_in_valid, sp_in_ready, sp_c, sp_out_valid, sp_out_ready;
    logic [SP_PW-1:0]  sp_pre;
    logic [SP_SAW-1:0] sp_shamt, sp_lza;
    logic [SP_EW-1:0]  sp_res, sp_nexp;
    logic [SP_NW-1:0]  sp_norm;
    logic              sp_sticky, sp_expc, sp_zero, sp_uf;

    logic              dp_in_valid, dp_in_ready, dp_c, dp_out_valid, dp_out_ready;
    logic [DP_PW-1:0]  dp_pre;
    logic [DP_SAW-1:0] dp_shamt, dp_lza;
    logic [DP_EW-1:0]  dp_res, dp_nexp;
    logic [DP_NW-1:0]  dp_norm;
    logic              dp_sticky, dp_expc, dp_zero, dp_uf;

    normalize_exp_update_pipe #(.SIG_WIDTH(SP_SW), .EXP_WIDTH(SP_EW)) u_sp (
        .clk(clk), .rst_n(rst_n), .in_valid(sp_in_valid), .in_ready(sp_in_ready),
        .prenormalized(sp_pre), .shamt(sp_shamt), .lza_shamt(sp_lza),
        .c_exp_is_small(sp_c), .res_exp(sp_res), .out_valid(sp_out_valid),
        .out_ready(sp_out_ready), .normalized(sp_norm), .sticky(sp_sticky),
        .normalized_exp(sp_nexp), .exp_correction(sp_expc), .zero_out(sp_zero),
        .underflow(sp_uf)
    );

    normalize_exp_update_pipe u_dp (
        .clk(clk), .rst_n(rst_n), .in_valid(dp_in_valid), .in_ready(dp_in_ready),
        .prenormalized(dp_pre), .shamt(dp_shamt), .lza_shamt(dp_lza),
        .c_exp_is_small(dp_c), .res_exp(dp_res), .out_valid(dp_out_valid),
        .out_ready(dp_out_ready), .normalized(dp_norm), .sticky(dp_sticky),
        .normalized_exp(dp_nexp), .exp_correction(dp_expc), .zero_out(dp_zero),
        .underflow(dp_uf)
    );

    typedef struct {
        logic [255:0] norm;
        logic         sticky;
        logic [31:0]  nexp;
        logic         expc;
        logic         zero;
        logic         uf;
    } exp_t;

    exp_t sp_q[$];
    exp_t dp_q[$];
    int   checks = 0;
    int   failures = 0;
    logic rand_rdy = 1'b0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: shift, then walk the leading one up by at most 3, then apply the exponent rules
    function automatic exp_t model(input int sw, input int ew, input logic [255:0] pre,
                                   input int shamt, input int lza, input bit c, input int res);
        exp_t r;
        int pw, nw, sh, e, corr;
        logic [255:0] mask, v;
        pw   = 3 * (sw + 1) + 8;
        nw   = sw + 4;
        mask = (256'd1 << pw) - 1;
        if (shamt >= sw + 4) begin
            sh = lza + sw + 3;
            e  = res - lza + 3 + (c ? 1 : 0) - ((shamt == 2 * (sw + 1) + 8) ? 1 : 0);
        end else begin
            sh = shamt;
            e  = res + 1;
        end
        v = (sh >= 256) ? 256'd0 : ((pre << sh) & mask);
        r.expc = ~v[pw-1];
        corr = 0;
        while (corr < 3 && !v[pw-1]) begin
            v = (v << 1) & mask;
            corr++;
        end
        e = e - corr;
        r.norm   = v >> (pw - nw);
        r.sticky = |(v & ((256'd1 << (pw - nw)) - 1));
        r.nexp   = 32'(e) & ((32'd1 << ew) - 1);
        r.uf     = (e <= 0);
        r.zero   = 1'b0;
        if (pre == 256'd0) begin
            r.norm = '0; r.sticky = 0; r.nexp = 0; r.uf = 0; r.zero = 1;
        end
        return r;
    endfunction

    function automatic logic [255:0] rand_pre(input int pw);
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        case ($urandom % 8)
            0:       v = '0;
            1, 2:    v = 256'd1 << $urandom_range(0, pw - 1);
            3:       v = v >> $urandom_range(0, pw);
            default: ;
        endcase
        return v & ((256'd1 << pw) - 1);
    endfunction

    task automatic send_sp(input logic [255:0] pre, input int shamt, input int lza, input bit c, input int res);
        int n = 0;
        sp_pre = pre[SP_PW-1:0]; sp_shamt = 7'(shamt); sp_lza = 7'(lza);
        sp_c = c; sp_res = 8'(res); sp_in_valid = 1'b1;
        @(negedge clk);
        while (!sp_in_ready && n < 200) begin n++; @(negedge clk); end
        if (!sp_in_ready) check("sp_in_ready_timeout", 0, 1);
        else sp_q.push_back(model(SP_SW, SP_EW, pre, shamt, lza, c, res));
        @(posedge clk); #1;
        sp_in_valid = 1'b0;
    endtask

    task automatic send_dp(input logic [255:0] pre, input int shamt, input int lza, input bit c, input int res);
        int n = 0;
        dp_pre = pre[DP_PW-1:0]; dp_shamt = 8'(shamt); dp_lza = 8'(lza);
        dp_c = c; dp_res = 11'(res); dp_in_valid = 1'b1;
        @(negedge clk);
        while (!dp_in_ready && n < 200) begin n++; @(negedge clk); end
        if (!dp_in_ready) check("dp_in_ready_timeout", 0, 1);
        else dp_q.push_back(model(DP_SW, DP_EW, pre, shamt, lza, c, res));
        @(posedge clk); #1;
        dp_in_valid = 1'b0;
    endtask

    task automatic send_rand(input bit dp);
        int sw, pw, saw, ew, shamt;
        sw  = dp ? DP_SW : SP_SW;
        pw  = dp ? DP_PW : SP_PW;
        saw = dp ? DP_SAW : SP_SAW;
        ew  = dp ? DP_EW : SP_EW;
        shamt = ($urandom % 8 == 0) ? 2 * (sw + 1) + 8 : $urandom_range(0, (1 << saw) - 1);
        if (dp) send_dp(rand_pre(pw), shamt, $urandom_range(0, pw), 1'($urandom), $urandom_range(0, (1 << ew) - 1));
        else    send_sp(rand_pre(pw), shamt, $urandom_range(0, pw), 1'($urandom), $urandom_range(0, (1 << ew) - 1));
    endtask

    task automatic drain();
        int n = 0;
        while ((sp_q.size() != 0 || dp_q.size() != 0) && n < 500) begin n++; @(negedge clk); end
        check("drain_sp_empty", 256'(sp_q.size()), 0);
        check("drain_dp_empty", 256'(dp_q.size()), 0);
        @(posedge clk); #1;
    endtask

    // SP monitor: pop and compare on every transferred output beat
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && sp_out_valid && sp_out_ready) begin
            if (sp_q.size() == 0) check("sp_unexpected_beat", 1, 0);
            else begin
                e = sp_q.pop_front();
                check("sp_normalized", sp_norm, e.norm);
                check("sp_sticky", sp_sticky, e.sticky);
                check("sp_normalized_exp", sp_nexp, e.nexp);
                check("sp_exp_correction", sp_expc, e.expc);
                check("sp_zero_out", sp_zero, e.zero);
                check("sp_underflow", sp_uf, e.uf);
            end
        end
    end

    // DP monitor
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && dp_out_valid && dp_out_ready) begin
            if (dp_q.size() == 0) check("dp_unexpected_beat", 1, 0);
            else begin
                e = dp_q.pop_front();
                check("dp_normalized", dp_norm, e.norm);
                check("dp_sticky", dp_sticky, e.sticky);
                check("dp_normalized_exp", dp_nexp, e.nexp);
                check("dp_exp_correction", dp_expc, e.expc);
                check("dp_zero_out", dp_zero, e.zero);
                check("dp_underflow", dp_uf, e.uf);
            end
        end
    end

    // Randomised downstream backpressure
    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            sp_out_ready = ($urandom % 4) != 0;
            dp_out_ready = ($urandom % 4) != 0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        sp_in_valid = 0; sp_pre = '0; sp_shamt = '0; sp_lza = '0; sp_c = 0; sp_res = '0; sp_out_ready = 1;
        dp_in_valid = 0; dp_pre = '0; dp_shamt = '0; dp_lza = '0; dp_c = 0; dp_res = '0; dp_out_ready = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_sp_out_valid", sp_out_valid, 0);
        check("reset_sp_in_ready", sp_in_ready, 1);
        check("reset_sp_outputs", {sp_norm, sp_nexp, sp_sticky, sp_expc, sp_zero, sp_uf}, 0);
        check("reset_dp_out_valid", dp_out_valid, 0);
        check("reset_dp_in_ready", dp_in_ready, 1);
        check("reset_dp_outputs", {dp_norm, dp_nexp, dp_sticky, dp_expc, dp_zero, dp_uf}, 0);
        @(posedge clk); #1;

        // Two-cycle latency on the first SP beat
        send_sp(256'd1 << 69, 10, 0, 0, 100);
        @(negedge clk);
        check("sp_latency_cycle1", sp_out_valid, 0);
        @(negedge clk);
        check("sp_latency_cycle2", sp_out_valid, 1);
        @(posedge clk); #1;

        // Directed SP cases: correction, low-portion shifts, zero, underflow
        send_sp((256'd1 << 66) | 256'd1, 10, 0, 0, 100);
        send_sp(256'd1 << 48, 30, 5, 1, 100);
        send_sp(256'd1 << 48, 56, 5, 1, 100);
        send_sp(256'd0, 10, 0, 0, 100);
        send_sp((256'd1 << 66) | 256'd1, 10, 0, 0, 1);
        drain();

        // Random traffic on both precisions with backpressure
        rand_rdy = 1'b1;
        fork
            for (int i = 0; i < 150; i++) send_rand(1'b0);
            for (int j = 0; j < 150; j++) send_rand(1'b1);
        join
        rand_rdy = 1'b0;
        @(posedge clk); #2;
        sp_out_ready = 1; dp_out_ready = 1;
        drain();

        // DP stall: 4 back-to-back beats against a blocked output
        dp_out_ready = 0;
        fork
            for (int k = 0; k < 4; k++) send_rand(1'b1);
            begin
                repeat (2) @(posedge clk);
                @(negedge clk);
                check("dp_stall_in_ready", dp_in_ready, 0);
                check("dp_stall_out_valid", dp_out_valid, 1);
                repeat (3) begin
                    check("dp_stall_hold_norm", dp_norm, dp_q[0].norm);
                    check("dp_stall_hold_exp", dp_nexp, dp_q[0].nexp);
                    @(negedge clk);
                end
                @(posedge clk); #1;
                dp_out_ready = 1;
            end
        join
        drain();

        // Asynchronous reset with both DP stages full
        dp_out_ready = 0;
        send_dp(rand_pre(DP_PW), 5, 0, 0, 300);
        send_dp(rand_pre(DP_PW), 7, 0, 0, 400);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_out_valid", dp_out_valid, 0);
        dp_q.delete();
        sp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_reset_in_ready", dp_in_ready, 1);
        dp_out_ready = 1;
        repeat (5) begin
            @(negedge clk);
            check("post_reset_no_stale", dp_out_valid, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
